// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
//   arb_state_e : arbiter state (IDLE = no owner, BUSY = one owner)
//   clog2()     : constant-function ceiling log2 used for index/counter widths
package fifo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Smallest r with 2**r >= n. Returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker, purely combinational.
//   req   : request vector, bit i = requester i
//   ptr   : index with highest priority this round
//   idx   : first set req bit found scanning ptr, ptr+1, ... modulo NREQ
//   valid : at least one request is set (idx is 0 otherwise)
module rr_pick
  import fifo_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] idx,
  output logic            valid
);

  logic [ID_W-1:0] cand;

  // NOTE: every variable written in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = ID_W'((int'(ptr) + i) % NREQ);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter in front of a FIFO write port.
//   clk, rst : single clock, synchronous active-high reset
//   req, din : per-requester write request and flattened data
//              (din[i*DSIZE +: DSIZE] belongs to requester i)
//   ack      : beat of requester i accepted this cycle
//   gnt      : registered one-hot grant, zero when idle
//   gnt_id   : index of the current owner, zero when idle
//   wfull    : FIFO full flag
//   winc     : FIFO write enable
//   wdata    : FIFO write data
// One owner holds the port for up to BURST accepted beats, or until it drops
// its request. Every release passes through exactly one IDLE cycle, and the
// priority pointer moves just past the released owner.
module fifo_wr_arb
  import fifo_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DSIZE-1:0]    din,
  output logic [NREQ-1:0]          ack,
  output logic [NREQ-1:0]          gnt,
  output logic [clog2(NREQ)-1:0]   gnt_id,
  input  logic                     wfull,
  output logic                     winc,
  output logic [DSIZE-1:0]         wdata
);

  localparam int ID_W  = clog2(NREQ);
  localparam int CNT_W = clog2(BURST + 1);

  localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NREQ - 1);

  arb_state_e       state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]  ptr, ptr_d;
  logic [CNT_W-1:0] count, count_d, count_inc;

  logic [ID_W-1:0]  pick_idx;
  logic             pick_valid;
  logic             own_req;
  logic [DSIZE-1:0] own_data;
  logic             beat;
  logic             busy;

  rr_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Request bit and data slice of the current owner.
  always_comb begin
    own_req  = 1'b0;
    own_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id_q == ID_W'(i)) begin
        own_req  = req[i];
        own_data = din[i*DSIZE +: DSIZE];
      end
    end
  end

  // A beat is accepted only while an owner exists, still requests, and the
  // FIFO has room. rst gates it so a burst aborted by reset loses no data
  // silently: the reset cycle itself accepts nothing.
  assign busy      = (state_q == BUSY) && !rst;
  assign beat      = busy && own_req && !wfull;
  assign count_inc = count + 1'b1;

  assign winc   = beat;
  assign ack    = beat ? gnt_q : '0;
  assign wdata  = busy ? own_data : '0;
  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    ptr_d    = ptr;
    count_d  = count;

    case (state_q)
      IDLE: begin
        // Requests arriving while busy are not looked at until here, so a
        // waiting requester never preempts the owner.
        if (pick_valid) begin
          state_d  = BUSY;
          gnt_d    = NREQ'(1) << pick_idx;
          gnt_id_d = pick_idx;
          count_d  = '0;
        end
      end

      BUSY: begin
        if (beat) count_d = count_inc;
        // Release on an abandoned request or on the last beat of the burst.
        // The pointer moves past the owner so it queues behind everyone else.
        if (!own_req || (beat && count_inc == BURST_C)) begin
          state_d  = IDLE;
          gnt_d    = '0;
          gnt_id_d = '0;
          ptr_d    = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values of all others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      ptr      <= '0;
      count    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      ptr      <= ptr_d;
      count    <= count_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed and randomised checks for fifo_wr_arb (NREQ=4, BURST=4, DSIZE=8).
// Inputs change 1 time unit after posedge clk; outputs are sampled 1 unit later.
// In directed tests requester i presents data {i, cycle} on its din slice.
module tb_fifo_wr_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] din;
  logic [3:0]  ack;
  logic [3:0]  gnt;
  logic [1:0]  gnt_id;
  logic        wfull;
  logic        winc;
  logic [7:0]  wdata;

  int assertions = 0;
  int failures   = 0;

  fifo_wr_arb #(
    .DSIZE (8),
    .NREQ  (4),
    .BURST (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .din    (din),
    .ack    (ack),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .wfull  (wfull),
    .winc   (winc),
    .wdata  (wdata)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] id_of(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  // Advance one cycle, apply inputs, let combinational outputs settle.
  task automatic drive(input logic [3:0] r, input logic wf, input logic rs, input int c);
    @(posedge clk);
    #1;
    req   = r;
    wfull = wf;
    rst   = rs;
    for (int i = 0; i < 4; i++) din[i*8 +: 8] = {4'(i), 4'(c)};
    #1;
  endtask

  task automatic do_reset();
    drive(4'b0000, 1'b0, 1'b1, 0);
    drive(4'b0000, 1'b0, 1'b1, 0);
    drive(4'b0000, 1'b0, 1'b0, 0);
  endtask

  task automatic test_reset();
    // Requests present while in reset must not be granted.
    for (int c = 0; c < 3; c++) begin
      drive(4'b1111, 1'b0, (c < 2), c);
      assertions += 7;
      if (gnt !== 4'b0000) begin failures++; $display("FAIL reset gnt c%0d: got %b want 0000", c, gnt); end
      if (gnt_id !== 2'd0) begin failures++; $display("FAIL reset gnt_id c%0d: got %0d want 0", c, gnt_id); end
      if (winc !== 1'b0) begin failures++; $display("FAIL reset winc c%0d: got %b want 0", c, winc); end
      if (ack !== 4'b0000) begin failures++; $display("FAIL reset ack c%0d: got %b want 0000", c, ack); end
      if (wdata !== 8'h00) begin failures++; $display("FAIL reset wdata c%0d: got %h want 00", c, wdata); end
      if (dut.ptr !== 2'd0) begin failures++; $display("FAIL reset ptr c%0d: got %0d want 0", c, dut.ptr); end
      if (dut.count !== 3'd0) begin failures++; $display("FAIL reset count c%0d: got %0d want 0", c, dut.count); end
    end
  endtask

  task automatic test_single_burst();
    logic [3:0] v_req [10];
    logic [3:0] v_gnt [10];
    logic       v_winc[10];
    logic [1:0] e_id;
    logic [7:0] e_wd;
    v_req  = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0};
    v_gnt  = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0};
    v_winc = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int c = 0; c < 10; c++) begin
      drive(v_req[c], 1'b0, 1'b0, c);
      e_id = id_of(v_gnt[c]);
      e_wd = (v_gnt[c] != 4'h0) ? {2'b00, e_id, 4'(c)} : 8'h00;
      assertions += 5;
      if (gnt !== v_gnt[c]) begin failures++; $display("FAIL burst gnt c%0d: got %b want %b", c, gnt, v_gnt[c]); end
      if (gnt_id !== e_id) begin failures++; $display("FAIL burst gnt_id c%0d: got %0d want %0d", c, gnt_id, e_id); end
      if (winc !== v_winc[c]) begin failures++; $display("FAIL burst winc c%0d: got %b want %b", c, winc, v_winc[c]); end
      if (ack !== (v_winc[c] ? v_gnt[c] : 4'h0)) begin failures++; $display("FAIL burst ack c%0d: got %b", c, ack); end
      if (wdata !== e_wd) begin failures++; $display("FAIL burst wdata c%0d: got %h want %h", c, wdata, e_wd); end
    end
    assertions++;
    if (dut.ptr !== 2'd1) begin failures++; $display("FAIL burst ptr: got %0d want 1", dut.ptr); end
  endtask

  task automatic test_round_robin();
    logic [3:0] e_gnt;
    logic       e_winc;
    do_reset();
    // Tenures of 5 cycles: one IDLE cycle then 4 beats; owners 0,1,2,3,0.
    for (int c = 0; c < 26; c++) begin
      drive((c < 25) ? 4'b1111 : 4'b0000, 1'b0, 1'b0, c);
      if (c % 5 == 0 || c == 25) begin
        e_gnt  = 4'h0;
        e_winc = 1'b0;
      end else begin
        e_gnt  = 4'(1) << ((c / 5) % 4);
        e_winc = 1'b1;
      end
      assertions += 3;
      if (gnt !== e_gnt) begin failures++; $display("FAIL rr gnt c%0d: got %b want %b", c, gnt, e_gnt); end
      if (winc !== e_winc) begin failures++; $display("FAIL rr winc c%0d: got %b want %b", c, winc, e_winc); end
      if (ack !== (e_winc ? e_gnt : 4'h0)) begin failures++; $display("FAIL rr ack c%0d: got %b", c, ack); end
    end
  endtask

  task automatic test_wfull_stall();
    logic [3:0] v_req [10];
    logic       v_wf  [10];
    logic [3:0] v_gnt [10];
    logic       v_winc[10];
    v_req  = '{4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0};
    v_wf   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    v_gnt  = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0};
    v_winc = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int c = 0; c < 10; c++) begin
      drive(v_req[c], v_wf[c], 1'b0, c);
      assertions += 3;
      if (gnt !== v_gnt[c]) begin failures++; $display("FAIL stall gnt c%0d: got %b want %b", c, gnt, v_gnt[c]); end
      if (winc !== v_winc[c]) begin failures++; $display("FAIL stall winc c%0d: got %b want %b", c, winc, v_winc[c]); end
      if (ack !== (v_winc[c] ? v_gnt[c] : 4'h0)) begin failures++; $display("FAIL stall ack c%0d: got %b", c, ack); end
      if (v_wf[c]) begin
        assertions += 2;
        if (dut.count !== 3'd2) begin failures++; $display("FAIL stall count c%0d: got %0d want 2", c, dut.count); end
        if (wdata !== {4'h2, 4'(c)}) begin failures++; $display("FAIL stall wdata c%0d: got %h", c, wdata); end
      end
    end
  endtask

  task automatic test_abandon();
    logic [3:0] v_req [8];
    logic [3:0] v_gnt [8];
    logic       v_winc[8];
    // After requester 1 abandons, ptr=2, so req 1001 is won by requester 3.
    v_req  = '{4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'h9, 4'h9, 4'h0};
    v_gnt  = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'h8, 4'h8};
    v_winc = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(v_req[c], 1'b0, 1'b0, c);
      assertions += 3;
      if (gnt !== v_gnt[c]) begin failures++; $display("FAIL abandon gnt c%0d: got %b want %b", c, gnt, v_gnt[c]); end
      if (winc !== v_winc[c]) begin failures++; $display("FAIL abandon winc c%0d: got %b want %b", c, winc, v_winc[c]); end
      if (ack !== (v_winc[c] ? v_gnt[c] : 4'h0)) begin failures++; $display("FAIL abandon ack c%0d: got %b", c, ack); end
      if (c == 4) begin
        assertions++;
        if (dut.ptr !== 2'd2) begin failures++; $display("FAIL abandon ptr: got %0d want 2", dut.ptr); end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [3:0] v_req [6];
    logic       v_rst [6];
    logic [3:0] v_gnt [6];
    logic       v_winc[6];
    logic [7:0] v_wd  [6];
    v_req  = '{4'h1, 4'h1, 4'h1, 4'h8, 4'h8, 4'h0};
    v_rst  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    v_gnt  = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h8, 4'h8};
    v_winc = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    v_wd   = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h34, 8'h35};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive(v_req[c], 1'b0, v_rst[c], c);
      assertions += 4;
      if (gnt !== v_gnt[c]) begin failures++; $display("FAIL rstmid gnt c%0d: got %b want %b", c, gnt, v_gnt[c]); end
      if (winc !== v_winc[c]) begin failures++; $display("FAIL rstmid winc c%0d: got %b want %b", c, winc, v_winc[c]); end
      if (ack !== (v_winc[c] ? v_gnt[c] : 4'h0)) begin failures++; $display("FAIL rstmid ack c%0d: got %b", c, ack); end
      if (wdata !== v_wd[c]) begin failures++; $display("FAIL rstmid wdata c%0d: got %h want %h", c, wdata, v_wd[c]); end
      if (c == 3) begin
        assertions += 2;
        if (dut.ptr !== 2'd0) begin failures++; $display("FAIL rstmid ptr: got %0d want 0", dut.ptr); end
        if (gnt_id !== 2'd0) begin failures++; $display("FAIL rstmid gnt_id: got %0d want 0", gnt_id); end
      end
      if (c == 4) begin
        assertions++;
        if (gnt_id !== 2'd3) begin failures++; $display("FAIL rstmid gnt_id: got %0d want 3", gnt_id); end
      end
    end
  endtask

  // Each requester emits its own sequence {id, seq}; every FIFO write must be
  // the next unconsumed item of exactly the acked requester.
  task automatic test_random();
    logic [3:0] r_req;
    logic [5:0] seq [4];
    logic [3:0] last_ack;
    logic [3:0] prev_gnt;
    logic [1:0] id;
    int         beats;
    r_req    = 4'h0;
    last_ack = 4'h0;
    prev_gnt = 4'h0;
    beats    = 0;
    for (int i = 0; i < 4; i++) seq[i] = 6'd0;
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (r_req[i]) begin
          if (last_ack[i]) begin
            seq[i] = seq[i] + 6'd1;
            if ($urandom_range(0, 1) == 0) r_req[i] = 1'b0;
          end else if ($urandom_range(0, 31) == 0) begin
            r_req[i] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          r_req[i] = 1'b1;
        end
        din[i*8 +: 8] = {2'(i), seq[i]};
      end
      req   = r_req;
      wfull = ($urandom_range(0, 3) == 0);
      #1;
      assertions += 3;
      if (winc && wfull) begin failures++; $display("FAIL rand winc_wfull c%0d: winc=%b wfull=%b", c, winc, wfull); end
      if ($countones(gnt) > 1) begin failures++; $display("FAIL rand gnt_onehot c%0d: got %b", c, gnt); end
      if (prev_gnt != 4'h0 && gnt != 4'h0 && gnt !== prev_gnt) begin
        failures++; $display("FAIL rand back_to_back c%0d: got %b after %b", c, gnt, prev_gnt);
      end
      if (gnt == 4'h0) beats = 0;
      if (winc) begin
        id = id_of(ack);
        beats++;
        assertions += 4;
        if (ack !== gnt || ack == 4'h0) begin failures++; $display("FAIL rand ack c%0d: got %b want %b", c, ack, gnt); end
        if (wdata !== {id, seq[id]}) begin failures++; $display("FAIL rand wdata c%0d: got %h want %h", c, wdata, {id, seq[id]}); end
        if (!r_req[id]) begin failures++; $display("FAIL rand ack_no_req c%0d: got ack %b req %b", c, ack, r_req); end
        if (beats > 4) begin failures++; $display("FAIL rand burst_len c%0d: got %0d want <=4", c, beats); end
      end else begin
        assertions++;
        if (ack !== 4'h0) begin failures++; $display("FAIL rand ack_idle c%0d: got %b want 0000", c, ack); end
      end
      last_ack = ack;
      prev_gnt = gnt;
    end
  endtask

  initial begin
    rst   = 1'b1;
    req   = 4'h0;
    din   = 32'h0;
    wfull = 1'b0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_wfull_stall();
    test_abandon();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
